// File: rtl/seq_controller_pkg.sv
// Shared types for the RISC sequence controller: phase bus, opcodes, controller states, strobe bundle.
package seq_controller_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        UPDATE  = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALTED    = 2'd1,
        ST_STEP_WAIT = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic sel;
        logic rd;
        logic wr;
        logic ld_ir;
        logic ld_ac;
        logic ld_pc;
        logic inc_pc;
        logic data_e;
        logic halt;
    } strobes_t;

    // Opcodes that read a memory operand and write the accumulator.
    function automatic logic is_aluop(opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/seq_controller_if.sv
// Phase bus, opcode/flag inputs and datapath strobes between sequencer (master) and datapath (slave).
// Optional single-step pins exist only when SEQ_SSTEP_EN is defined.
interface seq_controller_if
    import seq_controller_pkg::*;
#(
    parameter int CNT_W = 16
);
    phase_e             phase;
    logic [2:0]         opcode;
    logic               zero;
    logic               phase_en;
    logic               sel;
    logic               rd;
    logic               wr;
    logic               ld_ir;
    logic               ld_ac;
    logic               ld_pc;
    logic               inc_pc;
    logic               data_e;
    logic               halt;
    logic [CNT_W-1:0]   instr_cnt;
`ifdef SEQ_SSTEP_EN
    logic               step_mode;
    logic               step;
`endif

    modport master (
        input  phase, opcode, zero,
`ifdef SEQ_SSTEP_EN
               step_mode, step,
`endif
        output phase_en, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, instr_cnt
    );

    modport slave (
        output phase, opcode, zero,
`ifdef SEQ_SSTEP_EN
               step_mode, step,
`endif
        input  phase_en, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, instr_cnt
    );

endinterface

// File: rtl/seq_controller_decode.sv
// Combinational strobe table: phase, live/latched opcode, latched zero flag and controller state -> strobes.
module seq_decode
    import seq_controller_pkg::*;
(
    input  phase_e      phase,
    input  opcode_e     opcode,
    input  opcode_e     opc_q,
    input  logic        zero_q,
    input  ctrl_state_e state,
    output strobes_t    strb
);

    always_comb begin
        strb = '0;
        case (state)
            ST_HALTED: strb.halt = 1'b1;
            ST_RUN: begin
                case (phase)
                    FETCH: begin
                        strb.sel   = 1'b1;
                        strb.rd    = 1'b1;
                        strb.ld_ir = 1'b1;
                    end
                    // Only the live opcode is valid here; opc_q still holds the previous instruction.
                    DECODE: strb.rd = is_aluop(opcode);
                    EXECUTE: begin
                        if (is_aluop(opc_q)) begin
                            strb.rd    = 1'b1;
                            strb.ld_ac = 1'b1;
                        end else begin
                            case (opc_q)
                                OP_STO: begin
                                    strb.data_e = 1'b1;
                                    strb.wr     = 1'b1;
                                end
                                OP_JMP:  strb.ld_pc  = 1'b1;
                                OP_SKZ:  strb.inc_pc = zero_q;
                                OP_HLT:  strb.halt   = 1'b1;
                                default: ;
                            endcase
                        end
                    end
                    UPDATE: strb.inc_pc = !((opc_q == OP_JMP) || (opc_q == OP_HLT));
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_controller.sv
// Sequence controller: run/halt FSM, opcode and zero latches, retired-instruction counter.
// Define SEQ_SSTEP_EN to add single-step mode (step_mode/step pins and the STEP_WAIT state).
//
// state        | meaning
// ST_RUN       | phase generator enabled, strobes decoded from phase/opcode
// ST_HALTED    | HLT executed; generator frozen, only halt asserted until reset
// ST_STEP_WAIT | single-step mode parked at FETCH waiting for a step edge
module seq_controller
    import seq_controller_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    seq_controller_if.master bus
);

    ctrl_state_e      state, state_nxt, dec_state;
    opcode_e          opc_q;
    logic             zero_q;
    logic [CNT_W-1:0] cnt;
    logic             step_hold;
    logic             step_rise;
    logic             step_leave;
    logic             run_active;
    strobes_t         strb, strb_out;

`ifdef SEQ_SSTEP_EN
    logic step_s1, step_s2, step_s3, step_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
            step_s3 <= 1'b0;
        end else begin
            step_s1 <= bus.step;
            step_s2 <= step_s1;
            step_s3 <= step_s2;
        end
    end

    assign step_rise  = step_s2 & ~step_s3;
    // Holding FETCH in RUN for the one cycle before STEP_WAIT keeps the generator from slipping a phase.
    assign step_hold  = (state == ST_RUN) && bus.step_mode && (bus.phase == FETCH) && !step_grant;
    assign step_leave = !bus.step_mode || step_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            step_grant <= 1'b0;
        else if (((state == ST_STEP_WAIT) || step_hold) && step_rise)
            step_grant <= 1'b1;
        else if (run_active && (bus.phase == UPDATE))
            step_grant <= 1'b0;
    end
`else
    assign step_rise  = 1'b0;
    assign step_hold  = 1'b0;
    assign step_leave = 1'b1;
`endif

    assign run_active = rst_n && (state == ST_RUN) && !step_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (step_hold) begin
                    if (!step_rise)
                        state_nxt = ST_STEP_WAIT;
                end else if ((bus.phase == EXECUTE) && (opc_q == OP_HLT)) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED:    state_nxt = ST_HALTED;
            ST_STEP_WAIT: if (step_leave) state_nxt = ST_RUN;
            default:      state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q  <= OP_HLT;
            zero_q <= 1'b0;
        end else if (run_active && (bus.phase == DECODE)) begin
            opc_q  <= opcode_e'(bus.opcode);
            zero_q <= bus.zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (run_active && (bus.phase == UPDATE))
            cnt <= cnt + 1'b1;
    end

    assign dec_state = step_hold ? ST_STEP_WAIT : state;

    seq_decode u_decode (
        .phase  (bus.phase),
        .opcode (opcode_e'(bus.opcode)),
        .opc_q  (opc_q),
        .zero_q (zero_q),
        .state  (dec_state),
        .strb   (strb)
    );

    // The phase generator restarts at FETCH during reset, so strobes are forced low explicitly.
    assign strb_out = rst_n ? strb : '0;

    assign bus.phase_en  = run_active;
    assign bus.sel       = strb_out.sel;
    assign bus.rd        = strb_out.rd;
    assign bus.wr        = strb_out.wr;
    assign bus.ld_ir     = strb_out.ld_ir;
    assign bus.ld_ac     = strb_out.ld_ac;
    assign bus.ld_pc     = strb_out.ld_pc;
    assign bus.inc_pc    = strb_out.inc_pc;
    assign bus.data_e    = strb_out.data_e;
    assign bus.halt      = strb_out.halt;
    assign bus.instr_cnt = cnt;

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n) !(bus.rd && bus.wr));
    a_pc_excl:    assert property (@(posedge clk) disable iff (!rst_n) !(bus.ld_pc && bus.inc_pc));

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller with a behavioural phase generator closing the PHASE_EN loop.
module tb_seq_controller;
    import seq_controller_pkg::*;

    // Strobe vector order: phase_en sel rd wr ld_ir ld_ac ld_pc inc_pc data_e halt
    localparam logic [9:0] S_FETCH  = 10'b11101_00000;
    localparam logic [9:0] D_ALU    = 10'b10100_00000;
    localparam logic [9:0] D_NONE   = 10'b10000_00000;
    localparam logic [9:0] E_ALU    = 10'b10100_10000;
    localparam logic [9:0] E_STO    = 10'b10010_00010;
    localparam logic [9:0] E_JMP    = 10'b10000_01000;
    localparam logic [9:0] E_SKZ1   = 10'b10000_00100;
    localparam logic [9:0] E_HLT    = 10'b10000_00001;
    localparam logic [9:0] U_INC    = 10'b10000_00100;
    localparam logic [9:0] U_NONE   = 10'b10000_00000;
    localparam logic [9:0] S_HALTED = 10'b00000_00001;
    localparam logic [9:0] S_ZERO   = 10'b00000_00000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;
    logic [3:0] exp_cnt;
    logic [9:0] obs;

    seq_controller_if #(.CNT_W(4)) bus ();

    seq_controller #(.CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.phase <= FETCH;
        else if (bus.phase_en)
            bus.phase <= bus.phase.next();
    end

    assign obs = {bus.phase_en, bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac,
                  bus.ld_pc, bus.inc_pc, bus.data_e, bus.halt};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered on a falling edge inside FETCH; returns on the falling edge of the following FETCH.
    task automatic do_instr(input string tag, input logic [2:0] op, input logic z,
                            input logic [9:0] e_dec, input logic [9:0] e_exe, input logic [9:0] e_upd);
        bus.opcode = op;
        bus.zero   = z;
        #1;
        chk({tag, "_fetch_ph"}, bus.phase, FETCH);
        chk({tag, "_fetch"}, obs, S_FETCH);
        @(negedge clk); #1;
        chk({tag, "_decode_ph"}, bus.phase, DECODE);
        chk({tag, "_decode"}, obs, e_dec);
        @(negedge clk); #1;
        chk({tag, "_exec_ph"}, bus.phase, EXECUTE);
        chk({tag, "_exec"}, obs, e_exe);
        @(negedge clk); #1;
        chk({tag, "_update_ph"}, bus.phase, UPDATE);
        chk({tag, "_update"}, obs, e_upd);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        bus.opcode = 3'd0;
        bus.zero   = 1'b0;
`ifdef SEQ_SSTEP_EN
        bus.step_mode = 1'b0;
        bus.step      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst_strobes", obs, S_ZERO);
        chk("rst_cnt", bus.instr_cnt, 4'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 4'd0;

        do_instr("lda", 3'd5, 1'b0, D_ALU, E_ALU, U_INC);
        chk("cnt_lda", bus.instr_cnt, 4'd1);
        do_instr("sto", 3'd6, 1'b0, D_NONE, E_STO, U_INC);
        do_instr("jmp", 3'd7, 1'b0, D_NONE, E_JMP, U_NONE);
        do_instr("skz_z1", 3'd1, 1'b1, D_NONE, E_SKZ1, U_INC);
        do_instr("skz_z0", 3'd1, 1'b0, D_NONE, D_NONE, U_INC);
        do_instr("add", 3'd2, 1'b1, D_ALU, E_ALU, U_INC);
        do_instr("and", 3'd3, 1'b0, D_ALU, E_ALU, U_INC);
        do_instr("xor", 3'd4, 1'b0, D_ALU, E_ALU, U_INC);
        chk("cnt_after_8", bus.instr_cnt, 4'd8);

        do_instr("hlt", 3'd0, 1'b0, D_NONE, E_HLT, S_HALTED);
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("halt_phase", bus.phase, UPDATE);
            chk("halt_strobes", obs, S_HALTED);
            chk("halt_cnt", bus.instr_cnt, 4'd8);
            @(negedge clk);
        end

        rst_n = 1'b0;
        #1;
        chk("rst_from_halt_strobes", obs, S_ZERO);
        chk("rst_from_halt_cnt", bus.instr_cnt, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_instr("post_rst_add", 3'd2, 1'b0, D_ALU, E_ALU, U_INC);
        chk("post_rst_cnt", bus.instr_cnt, 4'd1);

        bus.opcode = 3'd2;
        @(negedge clk);
        @(negedge clk); #1;
        chk("mid_exec_ph", bus.phase, EXECUTE);
        chk("mid_exec_strobes", obs, E_ALU);
        rst_n = 1'b0;
        #1;
        chk("mid_exec_rst_strobes", obs, S_ZERO);
        chk("mid_exec_rst_cnt", bus.instr_cnt, 4'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 4'd0;

        for (int i = 1; i <= 17; i++) begin
            do_instr("wrap_add", 3'd2, 1'b0, D_ALU, E_ALU, U_INC);
            exp_cnt = exp_cnt + 4'd1;
            chk("wrap_cnt", bus.instr_cnt, exp_cnt);
            if (i == 15) chk("wrap_cnt_15", bus.instr_cnt, 4'd15);
            if (i == 16) chk("wrap_cnt_0", bus.instr_cnt, 4'd0);
        end
        chk("wrap_cnt_final", bus.instr_cnt, 4'd1);

`ifdef SEQ_SSTEP_EN
        bus.step_mode = 1'b1;
        bus.opcode    = 3'd2;
        #1;
        chk("step_hold_en", obs, S_ZERO);
        repeat (5) @(negedge clk);
        #1;
        chk("step_wait_ph", bus.phase, FETCH);
        chk("step_wait_strobes", obs, S_ZERO);
        chk("step_wait_cnt", bus.instr_cnt, 4'd1);
        bus.step = 1'b1;
        repeat (3) @(negedge clk);
        bus.step = 1'b0;
        for (int k = 0; k < 10 && bus.phase != DECODE; k++) @(negedge clk);
        chk("step_reach_decode", bus.phase, DECODE);
        for (int k = 0; k < 10 && bus.phase != FETCH; k++) @(negedge clk);
        #1;
        chk("step_back_fetch", bus.phase, FETCH);
        chk("step_cnt", bus.instr_cnt, 4'd2);
        repeat (5) @(negedge clk);
        #1;
        chk("step_single_ph", bus.phase, FETCH);
        chk("step_single_cnt", bus.instr_cnt, 4'd2);
        bus.step_mode = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("step_exit_en", bus.phase_en, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
